// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states,
// flag bit positions and the opcode legality check.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD     = 4'b0000;
  localparam logic [3:0] OP_SUB     = 4'b0001;
  localparam logic [3:0] OP_MUL     = 4'b0010;
  localparam logic [3:0] OP_ILL_DIV = 4'b0011;
  localparam logic [3:0] OP_AND     = 4'b0100;
  localparam logic [3:0] OP_OR      = 4'b0101;
  localparam logic [3:0] OP_NAND    = 4'b0110;
  localparam logic [3:0] OP_NOR     = 4'b0111;
  localparam logic [3:0] OP_XOR     = 4'b1000;
  localparam logic [3:0] OP_XNOR    = 4'b1001;
  localparam logic [3:0] OP_CMP_EQ  = 4'b1010;
  localparam logic [3:0] OP_CMP_GT  = 4'b1011;
  localparam logic [3:0] OP_CMP_LT  = 4'b1100;
  localparam logic [3:0] OP_SHR     = 4'b1101;
  localparam logic [3:0] OP_SHL     = 4'b1110;
  localparam logic [3:0] OP_IDLE    = 4'b1111;

  // Bit positions inside the 4-bit ALU flag vector {Shift, CMP, Logic, Arith}
  localparam int FLAG_ARITH = 0;
  localparam int FLAG_LOGIC = 1;
  localparam int FLAG_CMP   = 2;
  localparam int FLAG_SHIFT = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } seq_state_t;

  // Divide is not supported by the sequencer, and OP_IDLE is reserved as
  // the parked opcode that keeps the ALU output at zero.
  function automatic logic is_illegal_op(input logic [3:0] fun);
    return (fun == OP_ILL_DIV) || (fun == OP_IDLE);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so that
// full and empty can be told apart when the index bits are equal.
// The head entry is presented combinationally on rd_data.
module alu_cmd_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Advance the read and write pointers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the registered 16-bit ALU. Commands are
// buffered in a FIFO, issued one at a time, and the ALU result plus flags
// are returned as a registered response. Illegal opcodes are answered
// with an error response and never reach the ALU.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [3:0]        cmd_fun,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_fun,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err
);

  localparam int ENTRY_W = 2 * DATA_W + 4;

  seq_state_t         state;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic [DATA_W-1:0]  head_a;
  logic [DATA_W-1:0]  head_b;
  logic [3:0]         head_fun;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign head_a    = head[ENTRY_W-1 -: DATA_W];
  assign head_b    = head[DATA_W+3 -: DATA_W];
  assign head_fun  = head[3:0];

  alu_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data ({cmd_a, cmd_b, cmd_fun}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sequencer FSM with the registered ALU-input and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fun   <= OP_IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (is_illegal_op(head_fun)) begin
              rsp_data  <= '0;
              rsp_flags <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              alu_a   <= head_a;
              alu_b   <= head_b;
              alu_fun <= head_fun;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          rsp_data  <= alu_out;
          rsp_flags <= alu_flags;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
